// File: rtl/lot_pkg.sv
// Shared types and default sizing for the parking-lot RAM scheduler.
// The CLR state exists only when LOT_CLEAR_EN is defined.
package lot_pkg;

    localparam int LOT_CAPACITY = 3;
    localparam int LOT_HOURS    = 8;
    localparam int LOT_DATA_W   = 8;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_WAIT = 3'd2,
        ST_WR   = 3'd3
`ifdef LOT_CLEAR_EN
        ,
        ST_CLR  = 3'd4
`endif
    } lot_state_e;

endpackage

// File: rtl/lot_ram_sched_req_pending.sv
// Sticky request flag: a one-cycle pulse sets it, a grant clears it.
// A new pulse landing on the grant edge wins, so it is never lost.
module req_pending (
    input  logic clock,
    input  logic reset,
    input  logic set,
    input  logic clr,
    output logic pend
);

    // Pending flag register; reset discards any coincident pulse.
    always_ff @(posedge clock) begin
        if (reset) begin
            pend <= 1'b0;
        end else if (set) begin
            pend <= 1'b1;
        end else if (clr) begin
            pend <= 1'b0;
        end
    end

endmodule

// File: rtl/lot_ram_sched.sv
// Parking-lot occupancy tracker with a per-hour entry counter kept in an
// external synchronous RAM (read data valid one cycle after the address).
// Each accepted entry does a read-modify-write (RD -> WAIT -> WR) of the
// current hour's slot, incrementing it with saturation.
// Optional feature: define LOT_CLEAR_EN to zero the RAM after reset (CLR).
//
// Request handshake: enter_req/exit_req/hour_adv are single-cycle pulses with
// no ready; each is latched into a sticky pending flag and serviced later in
// IDLE (exit > enter > hour). Repeats while pending collapse into one request.
module lot_ram_sched
    import lot_pkg::*;
#(
    parameter int CAPACITY = LOT_CAPACITY,
    parameter int HOURS    = LOT_HOURS,
    parameter int DATA_W   = LOT_DATA_W,
    localparam int AW      = (HOURS > 1) ? $clog2(HOURS) : 1,
    localparam int OW      = $clog2(CAPACITY + 1)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enter_req,
    input  logic              exit_req,
    input  logic              hour_adv,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [AW-1:0]     ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    output logic [OW-1:0]     occupancy,
    output logic              full,
    output logic [AW-1:0]     hour,
    output logic              day_done,
    output logic              busy,
    output logic              enter_ack,
    output logic              enter_rej,
    output lot_state_e        state_dbg
);

`ifdef LOT_CLEAR_EN
    localparam lot_state_e RESET_STATE = ST_CLR;
`else
    localparam lot_state_e RESET_STATE = ST_IDLE;
`endif

    lot_state_e        state_q, state_d;
    logic [OW-1:0]     occ_q;
    logic [AW-1:0]     hour_q;
    logic              day_done_q;
    logic [DATA_W-1:0] cap_q;
    logic              rej_q;
    logic [DATA_W-1:0] inc_data;
    logic              pend_exit, pend_enter, pend_hour;
    logic              grant_exit, grant_enter, grant_hour;
`ifdef LOT_CLEAR_EN
    logic [AW-1:0]     clr_cnt_q;
`endif

    req_pending u_pend_exit (
        .clock (clock),
        .reset (reset),
        .set   (exit_req),
        .clr   (grant_exit),
        .pend  (pend_exit)
    );

    req_pending u_pend_enter (
        .clock (clock),
        .reset (reset),
        .set   (enter_req),
        .clr   (grant_enter),
        .pend  (pend_enter)
    );

    req_pending u_pend_hour (
        .clock (clock),
        .reset (reset),
        .set   (hour_adv),
        .clr   (grant_hour),
        .pend  (pend_hour)
    );

    assign full      = (occ_q == OW'(CAPACITY));
    assign occupancy = occ_q;
    assign hour      = hour_q;
    assign day_done  = day_done_q;
    assign enter_rej = rej_q;
    assign busy      = (state_q != ST_IDLE);
    assign state_dbg = state_q;
    assign inc_data  = (cap_q == {DATA_W{1'b1}}) ? cap_q : cap_q + DATA_W'(1);

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= RESET_STATE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and request arbitration; grants are only issued in IDLE.
    always_comb begin
        state_d     = state_q;
        grant_exit  = 1'b0;
        grant_enter = 1'b0;
        grant_hour  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pend_exit) begin
                    grant_exit = 1'b1;
                end else if (pend_enter) begin
                    grant_enter = 1'b1;
                    if (!full && !day_done_q) begin
                        state_d = ST_RD;
                    end
                end else if (pend_hour) begin
                    grant_hour = 1'b1;
                end
            end
            ST_RD:   state_d = ST_WAIT;
            ST_WAIT: state_d = ST_WR;
            ST_WR:   state_d = ST_IDLE;
`ifdef LOT_CLEAR_EN
            ST_CLR: begin
                if (clr_cnt_q == AW'(HOURS - 1)) begin
                    state_d = ST_IDLE;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // RAM-side outputs decoded from the state; hour is stable across RD..WR.
    always_comb begin
        ram_addr  = '0;
        ram_wdata = '0;
        ram_we    = 1'b0;
        enter_ack = 1'b0;
        case (state_q)
            ST_RD: begin
                ram_addr = hour_q;
            end
            ST_WR: begin
                ram_addr  = hour_q;
                ram_wdata = inc_data;
                ram_we    = 1'b1;
                enter_ack = 1'b1;
            end
`ifdef LOT_CLEAR_EN
            ST_CLR: begin
                // Held in CLR during reset, but no write until reset drops.
                ram_addr = clr_cnt_q;
                ram_we   = !reset;
            end
`endif
            default: begin
            end
        endcase
    end

    // Occupancy, hour, day flag, read capture and reject pulse.
    always_ff @(posedge clock) begin
        if (reset) begin
            occ_q      <= '0;
            hour_q     <= '0;
            day_done_q <= 1'b0;
            cap_q      <= '0;
            rej_q      <= 1'b0;
        end else begin
            rej_q <= 1'b0;
            if (grant_exit && (occ_q != '0)) begin
                occ_q <= occ_q - OW'(1);
            end
            if (grant_enter) begin
                if (full || day_done_q) begin
                    rej_q <= 1'b1;
                end else begin
                    occ_q <= occ_q + OW'(1);
                end
            end
            if (grant_hour) begin
                if (hour_q == AW'(HOURS - 1)) begin
                    day_done_q <= 1'b1;
                end else begin
                    hour_q <= hour_q + AW'(1);
                end
            end
            if (state_q == ST_WAIT) begin
                cap_q <= ram_rdata;
            end
        end
    end

`ifdef LOT_CLEAR_EN
    // Clear address counter walking 0..HOURS-1 while in CLR.
    always_ff @(posedge clock) begin
        if (reset) begin
            clr_cnt_q <= '0;
        end else if (state_q == ST_CLR) begin
            clr_cnt_q <= clr_cnt_q + AW'(1);
        end
    end
`endif

endmodule

// File: tb/tb_lot_ram_sched.sv
// Directed bench for lot_ram_sched with a behavioural RAM and a write log.
// Also exercises the clear sequence when LOT_CLEAR_EN is defined.
`timescale 1ns/1ps
module tb_lot_ram_sched;
    import lot_pkg::*;

    localparam int AW  = 3;
    localparam int DW  = 8;
    localparam int HRS = 8;

    logic          clock     = 1'b0;
    logic          reset     = 1'b1;
    logic          enter_req = 1'b0;
    logic          exit_req  = 1'b0;
    logic          hour_adv  = 1'b0;
    logic          preload   = 1'b0;
    logic [DW-1:0] ram_rdata;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic          ram_we;
    logic [1:0]    occupancy;
    logic          full;
    logic [AW-1:0] hour;
    logic          day_done;
    logic          busy;
    logic          enter_ack;
    logic          enter_rej;
    lot_state_e    state_dbg;

    logic [DW-1:0]    mem [HRS];
    logic [AW+DW-1:0] exp_q[$];
    logic [AW+DW-1:0] obs_q[$];
    int checks = 0;
    int errors = 0;

    // Clock and reset block.
    always #5 clock = ~clock;

    lot_ram_sched dut (
        .clock     (clock),
        .reset     (reset),
        .enter_req (enter_req),
        .exit_req  (exit_req),
        .hour_adv  (hour_adv),
        .ram_rdata (ram_rdata),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_we    (ram_we),
        .occupancy (occupancy),
        .full      (full),
        .hour      (hour),
        .day_done  (day_done),
        .busy      (busy),
        .enter_ack (enter_ack),
        .enter_rej (enter_rej),
        .state_dbg (state_dbg)
    );

    // Synchronous RAM model; logs every write for the scoreboard.
    always @(posedge clock) begin
        ram_rdata <= mem[ram_addr];
        if (preload) begin
            for (int i = 0; i < HRS; i++) mem[i] = DW'(8'h20 + i);
            mem[0] = 8'd5;
            mem[1] = 8'hFF;
        end else if (ram_we) begin
            obs_q.push_back({ram_addr, ram_wdata});
            mem[ram_addr] = ram_wdata;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_enter();
        enter_req = 1'b1;
        tick();
        enter_req = 1'b0;
    endtask

    task automatic pulse_exit();
        exit_req = 1'b1;
        tick();
        exit_req = 1'b0;
    endtask

    task automatic pulse_hour();
        hour_adv = 1'b1;
        tick();
        hour_adv = 1'b0;
    endtask

    task automatic do_preload();
        preload = 1'b1;
        tick();
        preload = 1'b0;
    endtask

`ifdef LOT_CLEAR_EN
    // Called just after reset drops: expect HOURS zero writes with busy=1.
    task automatic clear_phase(input bit with_entry);
        #1;
        for (int i = 0; i < HRS; i++) begin
            check("clr_we", 32'(ram_we), 32'd1);
            check("clr_addr", 32'(ram_addr), 32'(i));
            check("clr_wdata", 32'(ram_wdata), 32'd0);
            check("clr_busy", 32'(busy), 32'd1);
            exp_q.push_back({AW'(i), 8'h00});
            if (with_entry && i == 2) enter_req = 1'b1;
            tick();
            enter_req = 1'b0;
        end
    endtask
`endif

    // Directed stimulus and checks.
    initial begin
        preload = 1'b1;
        reset   = 1'b1;
        tick();
        preload = 1'b0;
        tick();
        check("rst_occ", 32'(occupancy), 32'd0);
        check("rst_hour", 32'(hour), 32'd0);
        check("rst_day", 32'(day_done), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        check("rst_we", 32'(ram_we), 32'd0);
        check("rst_addr", 32'(ram_addr), 32'd0);
        check("rst_ack", 32'(enter_ack), 32'd0);
        check("rst_rej", 32'(enter_rej), 32'd0);
`ifdef LOT_CLEAR_EN
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_state", 32'(state_dbg), 32'(ST_CLR));
        reset = 1'b0;
        clear_phase(1'b1);
        check("clr_idle", 32'(busy), 32'd0);
        check("clr_occ0", 32'(occupancy), 32'd0);
        tick();
        check("clr_ent_rd", 32'(state_dbg), 32'(ST_RD));
        check("clr_ent_occ", 32'(occupancy), 32'd1);
        tick(2);
        check("clr_ent_we", 32'(ram_we), 32'd1);
        check("clr_ent_wdata", 32'(ram_wdata), 32'd1);
        exp_q.push_back({3'd0, 8'd1});
        tick();
        pulse_exit();
        tick();
        check("clr_exit_occ", 32'(occupancy), 32'd0);
        do_preload();
`else
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_state", 32'(state_dbg), 32'(ST_IDLE));
        reset = 1'b0;
        tick();
`endif

        // Single entry: rdata 5 -> write 6 at address 0.
        pulse_enter();
        check("e1_idle", 32'(busy), 32'd0);
        tick();
        check("e1_rd", 32'(state_dbg), 32'(ST_RD));
        check("e1_occ", 32'(occupancy), 32'd1);
        check("e1_rd_we", 32'(ram_we), 32'd0);
        check("e1_rd_addr", 32'(ram_addr), 32'd0);
        tick();
        check("e1_wait", 32'(state_dbg), 32'(ST_WAIT));
        check("e1_wait_we", 32'(ram_we), 32'd0);
        tick();
        check("e1_wr_we", 32'(ram_we), 32'd1);
        check("e1_wr_addr", 32'(ram_addr), 32'd0);
        check("e1_wr_data", 32'(ram_wdata), 32'd6);
        check("e1_ack", 32'(enter_ack), 32'd1);
        exp_q.push_back({3'd0, 8'd6});
        tick();
        check("e1_done_we", 32'(ram_we), 32'd0);
        check("e1_done_ack", 32'(enter_ack), 32'd0);
        check("e1_done_busy", 32'(busy), 32'd0);

        // Fill the lot, then a fourth entry is rejected.
        for (int k = 0; k < 2; k++) begin
            pulse_enter();
            tick(4);
            exp_q.push_back({3'd0, DW'(7 + k)});
        end
        check("fill_occ", 32'(occupancy), 32'd3);
        check("fill_full", 32'(full), 32'd1);
        pulse_enter();
        tick();
        check("rej_pulse", 32'(enter_rej), 32'd1);
        check("rej_occ", 32'(occupancy), 32'd3);
        check("rej_busy", 32'(busy), 32'd0);
        tick();
        check("rej_clear", 32'(enter_rej), 32'd0);
        tick(3);
        check("rej_nowrite", 32'(obs_q.size()), 32'(exp_q.size()));

        // Simultaneous enter and exit on a full lot.
        enter_req = 1'b1;
        exit_req  = 1'b1;
        tick();
        enter_req = 1'b0;
        exit_req  = 1'b0;
        tick();
        check("both_exit_occ", 32'(occupancy), 32'd2);
        check("both_exit_full", 32'(full), 32'd0);
        tick();
        check("both_ent_occ", 32'(occupancy), 32'd3);
        check("both_ent_rd", 32'(state_dbg), 32'(ST_RD));
        tick(3);
        exp_q.push_back({3'd0, 8'd9});
        check("both_full", 32'(full), 32'd1);
        check("both_idle", 32'(busy), 32'd0);

        // hour_adv during WAIT is deferred until after WR.
        pulse_exit();
        tick();
        check("h_exit_occ", 32'(occupancy), 32'd2);
        pulse_enter();
        tick(2);
        check("h_wait", 32'(state_dbg), 32'(ST_WAIT));
        pulse_hour();
        check("h_wr_we", 32'(ram_we), 32'd1);
        check("h_wr_data", 32'(ram_wdata), 32'd10);
        check("h_wr_hour", 32'(hour), 32'd0);
        exp_q.push_back({3'd0, 8'd10});
        tick();
        check("h_idle_hour", 32'(hour), 32'd0);
        tick();
        check("h_after_hour", 32'(hour), 32'd1);
        for (int k = 0; k < 6; k++) begin
            pulse_hour();
            tick();
        end
        check("h_last_hour", 32'(hour), 32'd7);
        check("h_last_day", 32'(day_done), 32'd0);
        pulse_hour();
        tick();
        check("h_hold_hour", 32'(hour), 32'd7);
        check("h_day_done", 32'(day_done), 32'd1);
        pulse_exit();
        tick();
        pulse_enter();
        tick();
        check("day_rej", 32'(enter_rej), 32'd1);
        check("day_rej_occ", 32'(occupancy), 32'd2);
        check("day_rej_busy", 32'(busy), 32'd0);

        // Reset during WR, coincident entry discarded, then exit at zero.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("r2_hour", 32'(hour), 32'd0);
        check("r2_day", 32'(day_done), 32'd0);
`ifdef LOT_CLEAR_EN
        clear_phase(1'b0);
`endif
        do_preload();
        pulse_enter();
        tick(3);
        check("r3_wr_we", 32'(ram_we), 32'd1);
        check("r3_wr_data", 32'(ram_wdata), 32'd6);
        exp_q.push_back({3'd0, 8'd6});
        reset     = 1'b1;
        enter_req = 1'b1;
        tick();
        check("r3_abort_we", 32'(ram_we), 32'd0);
        check("r3_abort_ack", 32'(enter_ack), 32'd0);
        check("r3_occ", 32'(occupancy), 32'd0);
        reset     = 1'b0;
        enter_req = 1'b0;
`ifdef LOT_CLEAR_EN
        clear_phase(1'b0);
`endif
        tick();
        check("r3_discard", 32'(busy), 32'd0);
        check("r3_discard_occ", 32'(occupancy), 32'd0);
        pulse_exit();
        tick();
        check("uf_occ", 32'(occupancy), 32'd0);
        check("uf_full", 32'(full), 32'd0);

        // Saturating increment at hour 1 (slot preloaded with 0xFF).
`ifdef LOT_CLEAR_EN
        do_preload();
`endif
        pulse_hour();
        tick();
        check("sat_hour", 32'(hour), 32'd1);
        pulse_enter();
        tick(3);
        check("sat_we", 32'(ram_we), 32'd1);
        check("sat_addr", 32'(ram_addr), 32'd1);
        check("sat_data", 32'(ram_wdata), 32'hFF);
        exp_q.push_back({3'd1, 8'hFF});
        tick(2);

        // Scoreboard: every RAM write in order.
        check("wr_count", 32'(obs_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            check($sformatf("wr%0d", i), 32'(obs_q[i]), 32'(exp_q[i]));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lot_ram_sched.md
LOT_RAM_SCHED -- requirements
Module: lot_ram_sched

Interface
REQ-001 The block SHALL have parameter CAPACITY, default 3, giving maximum lot occupancy.
REQ-002 The block SHALL have parameter HOURS, default 8, giving the number of hourly RAM slots.
REQ-003 The block SHALL have parameter DATA_W, default 8, giving the RAM word width.
REQ-004 The block SHALL have port clock, input, 1, the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port reset, input, 1, a synchronous, active-high reset.
REQ-006 The block SHALL have port enter_req, input, 1, a one-cycle pulse marking a car arrival (already edge-detected upstream).
REQ-007 The block SHALL have port exit_req, input, 1, a one-cycle pulse marking a car departure.
REQ-008 The block SHALL have port hour_adv, input, 1, a one-cycle pulse that advances the hour.
REQ-009 The block SHALL have port ram_rdata, input, DATA_W, the RAM read data, valid one cycle after the address is presented.
REQ-010 The block SHALL have the RAM output ports ram_addr (clog2(HOURS)), ram_wdata (DATA_W) and ram_we (1).
REQ-011 The block SHALL have the status output ports occupancy (clog2(CAPACITY+1)), full (1), hour (clog2(HOURS)), day_done (1), busy (1), enter_ack (1) and enter_rej (1).

Function
REQ-012 The block SHALL latch each request pulse into a sticky pending flag (one per request type) at the clock edge that samples it.
REQ-013 The block SHALL clear a pending flag in the cycle it is serviced; a repeat pulse while the flag is already pending SHALL be absorbed.
REQ-014 The block SHALL service pending requests only in IDLE, with priority exit > enter > hour.
REQ-015 The FSM SHALL have the states IDLE, RD, WAIT and WR, plus CLR when LOT_CLEAR_EN is defined.
REQ-016 Exit service SHALL decrement occupancy at the next edge if occupancy > 0, otherwise drop the exit; the FSM SHALL stay in IDLE and SHALL NOT access the RAM.
REQ-017 Enter service when full=1 or day_done=1 SHALL pulse enter_rej for one cycle, leave occupancy unchanged, make no RAM access and stay in IDLE.
REQ-018 Enter service otherwise SHALL increment occupancy and move IDLE->RD.
REQ-019 In RD the block SHALL drive ram_addr=hour with ram_we=0, then move to WAIT.
REQ-020 In WAIT the block SHALL capture ram_rdata, then move to WR.
REQ-021 In WR the block SHALL drive ram_addr=hour, ram_wdata=captured+1 (saturating at 2^DATA_W-1) and ram_we=1, pulse enter_ack, then return to IDLE.
REQ-022 An enter pulse sampled at edge E SHALL produce its write (ram_we=1) in the cycle after edge E+3.
REQ-023 Hour service SHALL increment hour when hour < HOURS-1; at HOURS-1, hour SHALL hold and day_done SHALL set and stay set until reset.
REQ-024 The hour value SHALL be constant during RD, WAIT and WR, so a hour_adv arriving mid-RMW is deferred.
REQ-025 full SHALL equal (occupancy==CAPACITY); busy SHALL equal (state != IDLE).
REQ-026 ram_we SHALL be 1 only in WR (and in CLR when enabled).
REQ-027 Simultaneous enter_req and exit_req SHALL both be latched; exit is serviced first, so a full lot SHALL accept the entry.

Reset
REQ-028 Reset SHALL set occupancy, hour, day_done, all pending flags, enter_ack, enter_rej, ram_we, ram_addr and ram_wdata to 0 and the state to IDLE (CLR when LOT_CLEAR_EN is defined).
REQ-029 Reset asserted mid-RMW SHALL abort the access, with ram_we=0 from the cycle after the reset edge.
REQ-030 Request pulses coincident with reset SHALL be discarded.

Configuration
REQ-031 With LOT_CLEAR_EN defined, after reset the block SHALL spend HOURS cycles in CLR writing 0 to addresses 0..HOURS-1 with busy=1; requests arriving meanwhile SHALL latch as pending and be serviced afterwards.
REQ-032 With LOT_CLEAR_EN undefined, there SHALL be no CLR state, the block SHALL enter IDLE directly and the RAM contents SHALL be left untouched.

Structure
REQ-033 Package lot_pkg SHALL hold the state enum and the default CAPACITY, HOURS and DATA_W constants.
REQ-034 Sub-module req_pending (set on pulse, clear on grant, synchronous reset) SHALL be instantiated three times.

Verification
REQ-035 Bench: reset; enter_req pulse, ram_rdata=5 -> occupancy 1, write of 6 to address 0 four cycles after the sampling edge, enter_ack pulse.
REQ-036 Bench: four entries with CAPACITY=3 -> the fourth gets enter_rej, occupancy stays 3, no fourth RAM write.
REQ-037 Bench: full lot, enter_req and exit_req in the same cycle -> exit first (occupancy 2), then entry accepted (occupancy 3).
REQ-038 Bench: hour_adv during WAIT -> hour changes only after WR; 8 hour_adv pulses -> hour=7 and day_done=1.
REQ-039 Bench: reset during WR, then exit_req at occupancy 0 -> ram_we=0 next cycle, occupancy stays 0, no underflow.
REQ-040 Bench: with LOT_CLEAR_EN defined, reset -> 8 zero writes to addresses 0..7 with busy=1, after which an entry latched during CLR is serviced.
